// File: rtl/bpu_pkg.sv
// Shared types and constants for the overriding branch-predictor pipe.
package bpu_pkg;
  localparam int BPU_STAGES  = 3;
  localparam int BPU_VADDR_W = 39;
  localparam int BPU_PW      = 4;
  localparam int BPU_IDX_W   = 5;
  localparam int BPU_META_W  = 32;
  localparam int BPU_SW      = $clog2(BPU_STAGES);

  localparam logic [BPU_VADDR_W-1:0] RESET_PC = 39'h00_8000_0000;

  typedef logic [BPU_SW-1:0] bpu_stage_t;

  typedef struct packed {
    logic [BPU_VADDR_W-1:0]           start;
    logic [BPU_VADDR_W-1:0]           target;
    logic [BPU_PW-1:0]                size;
    logic                             taken;
    logic [BPU_IDX_W-1:0]             idx;
    logic [BPU_STAGES*BPU_META_W-1:0] meta;
  } BpuStageEntry;
endpackage

// File: rtl/bpu_override_arb.sv
// Override picker: the oldest (highest) overriding stage wins.
module bpu_override_arb
  import bpu_pkg::*;
#(
  parameter int N = BPU_STAGES
) (
  input  logic [N-1:0] i_ovr,
  output logic         o_any,
  output bpu_stage_t   o_idx
);
  always_comb begin
    o_any = |i_ovr;
    o_idx = '0;
    for (int s = 0; s < N; s++)
      if (i_ovr[s]) o_idx = bpu_stage_t'(s);
  end
endmodule

// File: rtl/bpu_override_pipe.sv
// N-stage overriding predictor pipe: owns the fetch PC,
// arbitrates overrides and delivers final-stage meta.
module bpu_override_pipe #(
  parameter int STAGES  = bpu_pkg::BPU_STAGES,
  parameter int VADDR_W = bpu_pkg::BPU_VADDR_W,
  parameter int PW      = bpu_pkg::BPU_PW,
  parameter int IDX_W   = bpu_pkg::BPU_IDX_W,
  parameter int META_W  = bpu_pkg::BPU_META_W,
  parameter logic [VADDR_W-1:0] RESET_PC = bpu_pkg::RESET_PC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [VADDR_W-1:0]         flush_pc_i,
  input  logic                       stall_i,
  input  logic [STAGES-1:0]          ready_i,
  input  logic [IDX_W-1:0]           fsq_idx_i,
  input  logic [STAGES*VADDR_W-1:0]  pred_target_i,
  input  logic [STAGES*PW-1:0]       pred_size_i,
  input  logic [STAGES-1:0]          pred_taken_i,
  input  logic [STAGES*META_W-1:0]   pred_meta_i,
  output logic [VADDR_W-1:0]         pc_o,
  output logic [STAGES-1:0]          stage_valid_o,
  output logic [STAGES*VADDR_W-1:0]  stage_pc_o,
  output logic                       fsq_en_o,
  output logic                       fsq_redirect_o,
  output logic [$clog2(STAGES)-1:0]  fsq_stage_o,
  output logic [VADDR_W-1:0]         fsq_start_o,
  output logic [VADDR_W-1:0]         fsq_target_o,
  output logic [PW-1:0]              fsq_size_o,
  output logic                       fsq_taken_o,
  output logic [IDX_W-1:0]           fsq_ridx_o,
  output logic                       last_en_o,
  output logic [IDX_W-1:0]           last_idx_o,
  output logic [STAGES*META_W-1:0]   last_meta_o
);
  import bpu_pkg::*;

  logic               w_stall;
  logic               w_adv;
  logic               w_any;
  bpu_stage_t         w_k;
  bpu_stage_t         w_sel;
  logic [STAGES-1:0]  w_vld;
  logic [STAGES-1:0]  w_ovr;
  logic [VADDR_W-1:0] r_pc;
  BpuStageEntry       w_held [STAGES];
  BpuStageEntry       w_cor  [STAGES];
  BpuStageEntry       w_out;

  assign w_stall = stall_i | ~&ready_i;
  assign w_adv   = ~w_stall & ~flush_i;

  // Stage 0 is the combinational fast predictor looking at pc_o.
  assign w_vld[0]  = 1'b1;
  assign w_held[0] = '{start:  r_pc,
                       target: '0,
                       size:   '0,
                       taken:  1'b0,
                       idx:    fsq_idx_i,
                       meta:   '0};

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      w_cor[s]        = w_held[s];
      w_cor[s].target = pred_target_i[s*VADDR_W +: VADDR_W];
      w_cor[s].size   = pred_size_i[s*PW +: PW];
      w_cor[s].taken  = pred_taken_i[s];
      w_cor[s].meta[s*META_W +: META_W] =
        pred_meta_i[s*META_W +: META_W];
    end
  end

  always_comb begin
    w_ovr = '0;
    for (int s = 1; s < STAGES; s++)
      w_ovr[s] = w_vld[s] &
        ((w_cor[s].target != w_held[s].target) |
         (w_cor[s].taken  != w_held[s].taken));
  end

  bpu_override_arb #(.N(STAGES)) u_arb (
    .i_ovr (w_ovr),
    .o_any (w_any),
    .o_idx (w_k)
  );

  assign w_sel = w_any ? w_k : '0;
  assign w_out = w_cor[w_sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_pc <= RESET_PC;
    else if (flush_i) r_pc <= flush_pc_i;
    else if (w_adv)   r_pc <= w_out.target;
  end

  for (genvar s = 1; s < STAGES; s++) begin : g_stg
    BpuStageEntry r_ent;
    logic         r_vld;
    logic         w_keep;

    // Blocks younger than the overriding stage are squashed.
    assign w_keep = ~w_any | (int'(w_k) <= s - 1);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_ent <= '0;
        r_vld <= 1'b0;
      end else if (flush_i) begin
        r_vld <= 1'b0;
      end else if (w_adv) begin
        r_ent <= w_cor[s-1];
        r_vld <= w_vld[s-1] & w_keep;
      end
    end

    assign w_held[s] = r_ent;
    assign w_vld[s]  = r_vld;
  end

  always_comb begin
    stage_pc_o = '0;
    for (int s = 0; s < STAGES; s++)
      stage_pc_o[s*VADDR_W +: VADDR_W] = w_held[s].start;
  end

  assign pc_o           = r_pc;
  assign stage_valid_o  = w_vld & {{(STAGES-1){1'b1}}, ~rst};
  assign fsq_en_o       = w_adv & ~rst;
  assign fsq_redirect_o = w_any & ~flush_i & ~rst;
  assign fsq_stage_o    = w_sel;
  assign fsq_start_o    = w_out.start;
  assign fsq_target_o   = w_out.target;
  assign fsq_size_o     = w_out.size;
  assign fsq_taken_o    = w_out.taken;
  assign fsq_ridx_o     = w_any ? w_out.idx : '0;
  assign last_en_o      = w_vld[STAGES-1] & w_adv & ~rst;
  assign last_idx_o     = w_held[STAGES-1].idx;
  assign last_meta_o    = w_cor[STAGES-1].meta;
endmodule

// File: tb/tb_bpu_override_pipe.sv
// Bench for bpu_override_pipe: directed scenarios plus random
// traffic checked against a block-level pipeline model.
module tb_bpu_override_pipe;
  localparam int S  = 3;
  localparam int VA = 39;
  localparam int PW = 4;
  localparam int IW = 5;
  localparam int MW = 32;
  localparam logic [VA-1:0] RPC = 39'h00_8000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic [VA-1:0]     flush_pc_i;
  logic              stall_i;
  logic [S-1:0]      ready_i;
  logic [IW-1:0]     fsq_idx_i;
  logic [S*VA-1:0]   pred_target_i;
  logic [S*PW-1:0]   pred_size_i;
  logic [S-1:0]      pred_taken_i;
  logic [S*MW-1:0]   pred_meta_i;
  logic [VA-1:0]     pc_o;
  logic [S-1:0]      stage_valid_o;
  logic [S*VA-1:0]   stage_pc_o;
  logic              fsq_en_o;
  logic              fsq_redirect_o;
  logic [1:0]        fsq_stage_o;
  logic [VA-1:0]     fsq_start_o;
  logic [VA-1:0]     fsq_target_o;
  logic [PW-1:0]     fsq_size_o;
  logic              fsq_taken_o;
  logic [IW-1:0]     fsq_ridx_o;
  logic              last_en_o;
  logic [IW-1:0]     last_idx_o;
  logic [S*MW-1:0]   last_meta_o;

  // per-stage predictor outputs driven by the bench
  logic [VA-1:0] d_tgt  [S];
  logic [PW-1:0] d_sz   [S];
  logic [S-1:0]  d_tk;
  logic [MW-1:0] d_meta [S];

  // model: one record per stage, stage 0 is the fetch PC
  bit            m_v    [S];
  logic [VA-1:0] m_pc;
  logic [VA-1:0] m_start[S];
  logic [VA-1:0] m_tgt  [S];
  logic [PW-1:0] m_sz   [S];
  bit            m_tk   [S];
  logic [IW-1:0] m_idx  [S];
  logic [MW-1:0] m_meta [S][S];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    pred_target_i = '0;
    pred_size_i   = '0;
    pred_meta_i   = '0;
    for (int s = 0; s < S; s++) begin
      pred_target_i[s*VA +: VA] = d_tgt[s];
      pred_size_i[s*PW +: PW]   = d_sz[s];
      pred_meta_i[s*MW +: MW]   = d_meta[s];
    end
    pred_taken_i = d_tk;
  end

  bpu_override_pipe dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .flush_pc_i     (flush_pc_i),
    .stall_i        (stall_i),
    .ready_i        (ready_i),
    .fsq_idx_i      (fsq_idx_i),
    .pred_target_i  (pred_target_i),
    .pred_size_i    (pred_size_i),
    .pred_taken_i   (pred_taken_i),
    .pred_meta_i    (pred_meta_i),
    .pc_o           (pc_o),
    .stage_valid_o  (stage_valid_o),
    .stage_pc_o     (stage_pc_o),
    .fsq_en_o       (fsq_en_o),
    .fsq_redirect_o (fsq_redirect_o),
    .fsq_stage_o    (fsq_stage_o),
    .fsq_start_o    (fsq_start_o),
    .fsq_target_o   (fsq_target_o),
    .fsq_size_o     (fsq_size_o),
    .fsq_taken_o    (fsq_taken_o),
    .fsq_ridx_o     (fsq_ridx_o),
    .last_en_o      (last_en_o),
    .last_idx_o     (last_idx_o),
    .last_meta_o    (last_meta_o)
  );

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [VA-1:0] rand_va();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if ($urandom_range(7) == 0)
      return 39'h7F_FFFF_FFC0 + VA'(r[5:0]);
    return r[VA-1:0];
  endfunction

  function automatic bit stalled();
    return stall_i || (ready_i != '1);
  endfunction

  // oldest live stage whose new prediction disagrees on target/taken
  function automatic int winner();
    for (int s = S - 1; s >= 1; s--)
      if (m_v[s] && (d_tgt[s] != m_tgt[s] || d_tk[s] != m_tk[s]))
        return s;
    return 0;
  endfunction

  task automatic model_reset();
    m_pc = RPC;
    for (int s = 0; s < S; s++) begin
      m_v[s] = 0; m_start[s] = '0; m_tgt[s] = '0;
      m_sz[s] = '0; m_tk[s] = 0; m_idx[s] = '0;
      for (int j = 0; j < S; j++) m_meta[s][j] = '0;
    end
  endtask

  task automatic model_update();
    int k;
    if (rst) begin
      model_reset();
      return;
    end
    if (flush_i) begin
      m_pc = flush_pc_i;
      for (int s = 1; s < S; s++) m_v[s] = 0;
      return;
    end
    if (stalled()) return;
    k = winner();
    // squash every block younger than the overrider
    for (int s = 1; s < k; s++) m_v[s] = 0;
    // every surviving block ages one stage, carrying its new prediction
    for (int s = S - 1; s >= 2; s--) begin
      m_v[s]     = m_v[s-1];
      m_start[s] = m_start[s-1];
      m_tgt[s]   = d_tgt[s-1];
      m_sz[s]    = d_sz[s-1];
      m_tk[s]    = d_tk[s-1];
      m_idx[s]   = m_idx[s-1];
      for (int j = 0; j < s - 1; j++) m_meta[s][j] = m_meta[s-1][j];
      m_meta[s][s-1] = d_meta[s-1];
    end
    m_v[1]       = (k == 0);
    m_start[1]   = m_pc;
    m_tgt[1]     = d_tgt[0];
    m_sz[1]      = d_sz[0];
    m_tk[1]      = d_tk[0];
    m_idx[1]     = fsq_idx_i;
    m_meta[1][0] = d_meta[0];
    m_pc = d_tgt[k];
  endtask

  task automatic compare_all();
    int k;
    bit en, red, lst;
    logic [S-1:0] ev;
    if (rst) begin
      chk("rst_pc", pc_o, RPC);
      chk("rst_valid", stage_valid_o, 0);
      chk("rst_en", fsq_en_o, 0);
      chk("rst_redirect", fsq_redirect_o, 0);
      chk("rst_last_en", last_en_o, 0);
      return;
    end
    k   = winner();
    en  = !flush_i && !stalled();
    red = !flush_i && (k != 0);
    lst = m_v[S-1] && en;
    for (int s = 0; s < S; s++) ev[s] = (s == 0) ? 1'b1 : m_v[s];
    chk("pc", pc_o, m_pc);
    chk("valid", stage_valid_o, ev);
    for (int s = 0; s < S; s++)
      if (ev[s])
        chk("stage_pc", stage_pc_o[s*VA +: VA],
            (s == 0) ? m_pc : m_start[s]);
    chk("fsq_en", fsq_en_o, en);
    chk("fsq_redirect", fsq_redirect_o, red);
    if (en || red) begin
      chk("fsq_stage", fsq_stage_o, k);
      chk("fsq_start", fsq_start_o, (k == 0) ? m_pc : m_start[k]);
      chk("fsq_target", fsq_target_o, d_tgt[k]);
      chk("fsq_size", fsq_size_o, d_sz[k]);
      chk("fsq_taken", fsq_taken_o, d_tk[k]);
    end
    if (red) chk("fsq_ridx", fsq_ridx_o, m_idx[k]);
    chk("last_en", last_en_o, lst);
    if (lst) begin
      chk("last_idx", last_idx_o, m_idx[S-1]);
      chk("last_meta", last_meta_o,
          {d_meta[2], m_meta[2][1], m_meta[2][0]});
    end
  endtask

  // predictors agree with held blocks; stage 0 predicts pc+32
  task automatic drive_defaults();
    flush_i    = 1'b0;
    stall_i    = 1'b0;
    ready_i    = '1;
    flush_pc_i = '0;
    fsq_idx_i  = IW'($urandom());
    d_tgt[0]   = m_pc + VA'(32);
    d_sz[0]    = PW'($urandom());
    d_tk[0]    = 1'($urandom());
    for (int s = 0; s < S; s++) d_meta[s] = $urandom();
    for (int s = 1; s < S; s++) begin
      d_tgt[s] = m_tgt[s];
      d_sz[s]  = m_sz[s];
      d_tk[s]  = m_tk[s];
    end
  endtask

  task automatic rand_drive();
    drive_defaults();
    flush_i    = ($urandom_range(19) == 0);
    flush_pc_i = rand_va();
    stall_i    = ($urandom_range(7) == 0);
    for (int s = 0; s < S; s++)
      ready_i[s] = ($urandom_range(15) != 0);
    if ($urandom_range(3) == 0) d_tgt[0] = rand_va();
    for (int s = 1; s < S; s++) begin
      if ($urandom_range(7) == 0) d_tgt[s] = rand_va();
      if ($urandom_range(15) == 0) d_tk[s] = ~d_tk[s];
      if ($urandom_range(1) == 0) d_sz[s] = PW'($urandom());
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    drive_defaults();
  endtask

  task automatic sample();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    drive_defaults();
    sample();
    chk("lit_rst_pc", pc_o, 39'h80000000);
    chk("lit_rst_valid", stage_valid_o, 3'b000);

    // c0..c2: sequential fetch, no overrides
    cyc(); rst = 1'b0; sample();
    chk("lit_c0_pc", pc_o, 39'h80000000);
    chk("lit_c0_en", fsq_en_o, 1);
    chk("lit_c0_red", fsq_redirect_o, 0);
    cyc(); sample();
    chk("lit_c1_pc", pc_o, 39'h80000020);
    cyc(); sample();
    chk("lit_c2_pc", pc_o, 39'h80000040);
    chk("lit_c2_en", fsq_en_o, 1);

    // c3: stage 1 overrides
    cyc();
    d_tgt[1] = 39'h80001000;
    sample();
    chk("lit_c3_red", fsq_redirect_o, 1);
    chk("lit_c3_stage", fsq_stage_o, 1);
    chk("lit_c3_start", fsq_start_o, 39'h80000040);
    chk("lit_c3_tgt", fsq_target_o, 39'h80001000);
    cyc(); sample();
    chk("lit_c4_pc", pc_o, 39'h80001000);
    chk("lit_c4_valid", stage_valid_o, 3'b101);
    chk("lit_c4_spc2", stage_pc_o[2*VA +: VA], 39'h80000040);

    // c6: stages 1 and 2 override together, stage 2 wins
    cyc(); sample();
    cyc();
    d_tgt[1] = 39'h80002000;
    d_tgt[2] = 39'h80003000;
    sample();
    chk("lit_c6_stage", fsq_stage_o, 2);
    chk("lit_c6_tgt", fsq_target_o, 39'h80003000);
    chk("lit_c6_last", last_en_o, 1);
    cyc(); sample();
    chk("lit_c7_pc", pc_o, 39'h80003000);
    chk("lit_c7_valid", stage_valid_o, 3'b001);

    // c8: flush during stall
    cyc();
    flush_i = 1'b1; stall_i = 1'b1;
    flush_pc_i = 39'h80004000;
    sample();
    chk("lit_c8_en", fsq_en_o, 0);
    chk("lit_c8_last", last_en_o, 0);
    cyc(); sample();
    chk("lit_c9_pc", pc_o, 39'h80004000);
    chk("lit_c9_valid", stage_valid_o, 3'b001);

    // c11..c12: one component not ready
    cyc(); sample();
    for (int i = 0; i < 2; i++) begin
      cyc();
      ready_i = 3'b101;
      sample();
      chk("lit_rdy_pc", pc_o, 39'h80004040);
      chk("lit_rdy_en", fsq_en_o, 0);
      chk("lit_rdy_last", last_en_o, 0);
    end

    // c13: resume; stage 2 changes only its size
    cyc();
    d_sz[2] = m_sz[2] + 4'd1;
    sample();
    chk("lit_c13_pc", pc_o, 39'h80004040);
    chk("lit_c13_valid", stage_valid_o, 3'b111);
    chk("lit_c13_spc2", stage_pc_o[2*VA +: VA], 39'h80004000);
    chk("lit_c13_red", fsq_redirect_o, 0);
    chk("lit_c13_last", last_en_o, 1);
    cyc(); sample();
    chk("lit_c14_pc", pc_o, 39'h80004060);

    // random traffic, with the odd mid-run reset
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      model_update();
      #1;
      rst = ($urandom_range(299) == 0);
      rand_drive();
      sample();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
